ft245_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single FT245 transmit channel between two byte-stream requesters: requester A is the ADC sample dump, requester B is the command-response/status path. It sits between the requesters and the FT245 driver's TX handshake (TXEN / TX_VALID / TX_DONE / TX_DATA). A grant is held for a whole packet, delimited by a LAST flag. A watchdog aborts a packet if the FT245 stalls.

---
 rtl/ft245_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ft245_tx_arbiter.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the FT245 transmit handshake between
// requester A (ADC dump) and requester B (command/status), with a stall watchdog.
module ft245_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_a,
    input  logic [7:0] i_data_a,
    input  logic       i_last_a,
    output logic       o_gnt_a,
    output logic       o_ack_a,
    input  logic       i_req_b,
    input  logic [7:0] i_data_b,
    input  logic       i_last_b,
    output logic       o_gnt_b,
    output logic       o_ack_b,
    output logic       o_txen,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_valid,
    input  logic       i_tx_done,
    output logic       o_err_timeout,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SEND,
        NEXT,
        RELEASE
    } state_t;

    localparam logic [15:0] WDOG_LIMIT = TIMEOUT_CYC - 16'd1;
    localparam logic [15:0] WDOG_MAX   = 16'hFFFF;

    state_t      r_state, w_state;
    logic        r_gntA, w_gntA;
    logic        r_gntB, w_gntB;
    logic        r_ackA, w_ackA;
    logic        r_ackB, w_ackB;
    logic        r_txen, w_txen;
    logic [7:0]  r_txData, w_txData;
    logic        r_lastReg, w_lastReg;
    logic        r_lastSrvB, w_lastSrvB;
    logic [15:0] r_wdog, w_wdog;
    logic        r_err, w_err;

    logic        w_selReq;
    logic [7:0]  w_selData;
    logic        w_selLast;

    // Only the granted requester's lines are looked at while a packet is open.
    assign w_selReq  = r_gntB ? i_req_b  : i_req_a;
    assign w_selData = r_gntB ? i_data_b : i_data_a;
    assign w_selLast = r_gntB ? i_last_b : i_last_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_gntA     <= 1'b0;
            r_gntB     <= 1'b0;
            r_ackA     <= 1'b0;
            r_ackB     <= 1'b0;
            r_txen     <= 1'b0;
            r_txData   <= 8'h00;
            r_lastReg  <= 1'b0;
            r_lastSrvB <= 1'b1;
            r_wdog     <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_gntA     <= w_gntA;
            r_gntB     <= w_gntB;
            r_ackA     <= w_ackA;
            r_ackB     <= w_ackB;
            r_txen     <= w_txen;
            r_txData   <= w_txData;
            r_lastReg  <= w_lastReg;
            r_lastSrvB <= w_lastSrvB;
            r_wdog     <= w_wdog;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_gntA     = r_gntA;
        w_gntB     = r_gntB;
        w_ackA     = 1'b0;
        w_ackB     = 1'b0;
        w_txen     = 1'b0;
        w_txData   = r_txData;
        w_lastReg  = r_lastReg;
        w_lastSrvB = r_lastSrvB;
        w_wdog     = r_wdog;
        w_err      = 1'b0;

        case (r_state)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (i_req_a && (!i_req_b || r_lastSrvB)) begin
                    w_gntA  = 1'b1;
                    w_state = WAIT_RDY;
                end else if (i_req_b) begin
                    w_gntB  = 1'b1;
                    w_state = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (!w_selReq) begin
                    w_state = RELEASE;
                end else if (!i_tx_valid) begin
                    w_txData  = w_selData;
                    w_lastReg = w_selLast;
                    w_txen    = 1'b1;
                    w_wdog    = 16'd0;
                    w_state   = SEND;
                end
            end
            SEND: begin
                if (r_wdog != WDOG_MAX) begin
                    w_wdog = r_wdog + 16'd1;
                end
                // A completion arriving on the timeout cycle still counts as success.
                if (i_tx_done) begin
                    w_ackA  = r_gntA;
                    w_ackB  = r_gntB;
                    w_state = r_lastReg ? RELEASE : NEXT;
                end else if (r_wdog >= WDOG_LIMIT) begin
                    w_err      = 1'b1;
                    w_gntA     = 1'b0;
                    w_gntB     = 1'b0;
                    w_lastSrvB = r_gntB;
                    w_state    = IDLE;
                end
            end
            NEXT: begin
                w_state = WAIT_RDY;
            end
            RELEASE: begin
                w_gntA     = 1'b0;
                w_gntB     = 1'b0;
                w_lastSrvB = r_gntB;
                w_state    = IDLE;
            end
            default: begin
                w_gntA  = 1'b0;
                w_gntB  = 1'b0;
                w_state = IDLE;
            end
        endcase
    end

    assign o_gnt_a       = r_gntA;
    assign o_gnt_b       = r_gntB;
    assign o_ack_a       = r_ackA;
    assign o_ack_b       = r_ackB;
    assign o_txen        = r_txen;
    assign o_tx_data     = r_txData;
    assign o_err_timeout = r_err;
    assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Self-checking bench for ft245_tx_arbiter: queue-based requesters, a latency
// driver model and a packet-order reference for round-robin service.
module tb_ft245_tx_arbiter;

    localparam logic [15:0] TO = 16'd16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reqA = 1'b0, lastA = 1'b0, reqB = 1'b0, lastB = 1'b0;
    logic [7:0] dataA = 8'h00, dataB = 8'h00;
    logic       txValid = 1'b0, txDone = 1'b0;
    logic       gntA, ackA, gntB, ackB, txen, err, busy;
    logic [7:0] txData;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] qA[$], qB[$];
    bit         lqA[$], lqB[$];
    bit         enA = 1'b0, enB = 1'b0;

    logic [7:0] txLog[$];
    bit         txOwn[$];
    int         txCyc[$];
    int         errCyc[$];
    int         ackACnt = 0, ackBCnt = 0;
    int         gntARise = -1, gntAFall = -1;
    bit         prevGntA = 1'b0;
    bit         sawBoth = 1'b0, sawGntB = 1'b0;
    bit         expLastB = 1'b1;

    int         doneCnt = 0;
    int         lat = 4;
    bit         randLat = 1'b0;
    int         hangCount = 0;

    ft245_tx_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_a      (reqA),
        .i_data_a     (dataA),
        .i_last_a     (lastA),
        .o_gnt_a      (gntA),
        .o_ack_a      (ackA),
        .i_req_b      (reqB),
        .i_data_b     (dataB),
        .i_last_b     (lastB),
        .o_gnt_b      (gntB),
        .o_ack_b      (ackB),
        .o_txen       (txen),
        .o_tx_data    (txData),
        .i_tx_valid   (txValid),
        .i_tx_done    (txDone),
        .o_err_timeout(err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters, FT245 driver and event logging, all evaluated mid-cycle.
    always @(negedge clk) begin
        if (gntA && gntB) sawBoth = 1'b1;
        if (gntB) sawGntB = 1'b1;
        if (gntA && !prevGntA) gntARise = cyc;
        if (!gntA && prevGntA) gntAFall = cyc;
        prevGntA = gntA;
        if (ackA) ackACnt++;
        if (ackB) ackBCnt++;
        if (err) errCyc.push_back(cyc);

        if (ackA && qA.size() > 0) begin
            void'(qA.pop_front());
            void'(lqA.pop_front());
        end
        if (ackB && qB.size() > 0) begin
            void'(qB.pop_front());
            void'(lqB.pop_front());
        end
        if (err && txOwn.size() > 0) begin
            if (txOwn[txOwn.size()-1] == 1'b0) begin
                while (qA.size() > 0) begin
                    bit l;
                    l = lqA.pop_front();
                    void'(qA.pop_front());
                    if (l) break;
                end
            end else begin
                while (qB.size() > 0) begin
                    bit l;
                    l = lqB.pop_front();
                    void'(qB.pop_front());
                    if (l) break;
                end
            end
        end

        txDone = 1'b0;
        if (txen) begin
            txLog.push_back(txData);
            txOwn.push_back(gntB);
            txCyc.push_back(cyc);
            if (hangCount > 0) hangCount--;
            else doneCnt = randLat ? int'($urandom_range(1, 8)) : lat;
        end else if (doneCnt > 0) begin
            doneCnt--;
            if (doneCnt == 0) txDone = 1'b1;
        end
        if (!rst_n) begin
            doneCnt = 0;
            txDone  = 1'b0;
        end

        reqA  = enA && (qA.size() > 0);
        dataA = (qA.size() > 0) ? qA[0] : 8'h00;
        lastA = (lqA.size() > 0) ? lqA[0] : 1'b0;
        reqB  = enB && (qB.size() > 0);
        dataB = (qB.size() > 0) ? qB[0] : 8'h00;
        lastB = (lqB.size() > 0) ? lqB[0] : 1'b0;
    end

    task automatic clearLogs();
        txLog.delete();
        txOwn.delete();
        txCyc.delete();
        errCyc.delete();
        ackACnt  = 0;
        ackBCnt  = 0;
        gntARise = -1;
        gntAFall = -1;
        sawGntB  = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (qA.size() == 0 && qB.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic waitTx(input int n, input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (txLog.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gntA, gntB, ackA, ackB, txen, err, busy} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b want=0000000", {gntA, gntB, ackA, ackB, txen, err, busy});
        end
        checks++;
        if (txData !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_tx_data got=%h want=00", txData);
        end
        rst_n = 1'b1;
        expLastB = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bit ok;
        for (int round = 0; round < 2; round++) begin
            clearLogs();
            enA = 1'b0;
            enB = 1'b0;
            lat = 2;
            qA = '{8'hA0 + 8'(round), 8'hA8};
            lqA = '{1'b0, 1'b1};
            qB = '{8'hB0 + 8'(round), 8'hB8};
            lqB = '{1'b0, 1'b1};
            @(negedge clk);
            enA = 1'b1;
            enB = 1'b1;
            waitDone(200, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL simul_done round=%0d got=timeout want=idle", round);
            end
            checks++;
            if (txLog.size() != 4) begin
                errors++;
                $display("[TB] FAIL simul_count round=%0d got=%0d want=4", round, txLog.size());
            end else begin
                checks++;
                if (txOwn[0] !== 1'b0 || txOwn[1] !== 1'b0 || txOwn[2] !== 1'b1 || txOwn[3] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL simul_order round=%0d got=%b%b%b%b want=0011",
                             round, txOwn[0], txOwn[1], txOwn[2], txOwn[3]);
                end
                checks++;
                if (txLog[0] !== 8'hA0 + 8'(round) || txLog[3] !== 8'hB8) begin
                    errors++;
                    $display("[TB] FAIL simul_bytes round=%0d got=%h,%h want=%h,b8",
                             round, txLog[0], txLog[3], 8'hA0 + 8'(round));
                end
            end
            expLastB = 1'b1;
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [7:0] expB[3];
        clearLogs();
        expB = '{8'h11, 8'h22, 8'h33};
        lat = 4;
        enB = 1'b0;
        qA = '{8'h11, 8'h22, 8'h33};
        lqA = '{1'b0, 1'b0, 1'b1};
        enA = 1'b1;
        waitDone(200, ok);
        checks++;
        if (!ok || txLog.size() != 3) begin
            errors++;
            $display("[TB] FAIL single_count got=%0d want=3", txLog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (txLog[i] !== expB[i] || txOwn[i] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL single_byte%0d got=%h/own%0d want=%h/own0", i, txLog[i], txOwn[i], expB[i]);
                end
            end
            checks++;
            if (txCyc[0] - gntARise != 1) begin
                errors++;
                $display("[TB] FAIL single_gnt_to_txen got=%0d want=1", txCyc[0] - gntARise);
            end
            checks++;
            if (txCyc[1] - txCyc[0] != lat + 3 || txCyc[2] - txCyc[1] != lat + 3) begin
                errors++;
                $display("[TB] FAIL single_spacing got=%0d,%0d want=%0d", txCyc[1] - txCyc[0], txCyc[2] - txCyc[1], lat + 3);
            end
            checks++;
            if (gntAFall - txCyc[2] != lat + 2) begin
                errors++;
                $display("[TB] FAIL single_gnt_drop got=%0d want=%0d", gntAFall - txCyc[2], lat + 2);
            end
        end
        checks++;
        if (ackACnt != 3 || ackBCnt != 0 || sawGntB || gntA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_acks got=ackA%0d ackB%0d gntB%0d gntA%0d want=ackA3 ackB0 gntB0 gntA0",
                     ackACnt, ackBCnt, sawGntB, gntA);
        end
        expLastB = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int c;
        clearLogs();
        txValid = 1'b1;
        qA = '{8'h5A};
        lqA = '{1'b1};
        enA = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (txLog.size() != 0 || gntA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold got=txen%0d gntA%0d want=txen0 gntA1", txLog.size(), gntA);
        end
        txValid = 1'b0;
        c = cyc;
        waitTx(1, 10, ok);
        checks++;
        if (!ok || txCyc[0] != c + 1 || txLog[0] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL bp_release got=ok%0d cyc%0d byte%h want=cyc%0d byte5a",
                     ok, ok ? txCyc[0] : -1, ok ? txLog[0] : 8'h00, c + 1);
        end
        waitDone(100, ok);
        expLastB = 1'b0;
    endtask

    task automatic test_watchdog();
        bit ok;
        clearLogs();
        lat = 3;
        hangCount = 1;
        enA = 1'b1;
        enB = 1'b0;
        qA = '{8'hA1};
        lqA = '{1'b1};
        qB = '{8'hB1};
        lqB = '{1'b1};
        waitTx(1, 20, ok);
        enB = 1'b1;
        for (int i = 0; i < 40 && errCyc.size() == 0; i++) @(negedge clk);
        checks++;
        if (errCyc.size() != 1 || txCyc.size() < 1) begin
            errors++;
            $display("[TB] FAIL wd_fired got=%0d want=1", errCyc.size());
        end else begin
            checks++;
            if (errCyc[0] - txCyc[0] != int'(TO)) begin
                errors++;
                $display("[TB] FAIL wd_latency got=%0d want=%0d", errCyc[0] - txCyc[0], TO);
            end
            checks++;
            if (gntAFall != errCyc[0] || ackACnt != 0) begin
                errors++;
                $display("[TB] FAIL wd_abort got=fall%0d ackA%0d want=fall%0d ackA0", gntAFall, ackACnt, errCyc[0]);
            end
        end
        waitDone(200, ok);
        checks++;
        if (!ok || txLog.size() != 2 || txOwn[1] !== 1'b1 || txLog[1] !== 8'hB1 || ackBCnt != 1) begin
            errors++;
            $display("[TB] FAIL wd_b_next got=n%0d ackB%0d want=n2 ackB1 byte b1", txLog.size(), ackBCnt);
        end
        expLastB = 1'b1;
    endtask

    task automatic test_fairness_random();
        bit ok;
        for (int it = 0; it < 5; it++) begin
            logic [7:0] refA[$], refB[$], expByte[$];
            bit refLA[$], refLB[$], expOwn[$];
            int nA, nB, ia, ib, len;
            bit lastSrvB, pickB, done;
            refA.delete(); refB.delete(); refLA.delete(); refLB.delete();
            expByte.delete(); expOwn.delete();
            clearLogs();
            enA = 1'b0;
            enB = 1'b0;
            randLat = 1'b1;
            nA = (it == 0) ? 3 : int'($urandom_range(1, 3));
            nB = (it == 0) ? 2 : int'($urandom_range(0, 3));
            for (int p = 0; p < nA; p++) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    refA.push_back(8'($urandom));
                    refLA.push_back(k == len - 1);
                end
            end
            for (int p = 0; p < nB; p++) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    refB.push_back(8'($urandom));
                    refLB.push_back(k == len - 1);
                end
            end
            // Whole packets alternate while both sides have work queued.
            lastSrvB = expLastB;
            ia = 0;
            ib = 0;
            while (ia < refA.size() || ib < refB.size()) begin
                if (ia < refA.size() && ib < refB.size()) pickB = !lastSrvB;
                else pickB = (ib < refB.size());
                done = 1'b0;
                while (!done) begin
                    if (pickB) begin
                        expByte.push_back(refB[ib]);
                        done = refLB[ib];
                        ib++;
                    end else begin
                        expByte.push_back(refA[ia]);
                        done = refLA[ia];
                        ia++;
                    end
                    expOwn.push_back(pickB);
                end
                lastSrvB = pickB;
            end
            qA = refA;
            lqA = refLA;
            qB = refB;
            lqB = refLB;
            @(negedge clk);
            enA = 1'b1;
            enB = 1'b1;
            waitDone(3000, ok);
            checks++;
            if (!ok || txLog.size() != expByte.size()) begin
                errors++;
                $display("[TB] FAIL rr_count it=%0d got=%0d want=%0d", it, txLog.size(), expByte.size());
            end else begin
                for (int i = 0; i < expByte.size(); i++) begin
                    checks++;
                    if (txLog[i] !== expByte[i] || txOwn[i] !== expOwn[i]) begin
                        errors++;
                        $display("[TB] FAIL rr_byte it=%0d i=%0d got=%h/own%0d want=%h/own%0d",
                                 it, i, txLog[i], txOwn[i], expByte[i], expOwn[i]);
                    end
                end
            end
            checks++;
            if (ackACnt != refA.size() || ackBCnt != refB.size()) begin
                errors++;
                $display("[TB] FAIL rr_acks it=%0d got=%0d/%0d want=%0d/%0d",
                         it, ackACnt, ackBCnt, refA.size(), refB.size());
            end
            expLastB = lastSrvB;
        end
        randLat = 1'b0;
    endtask

    task automatic test_early_drop();
        bit ok;
        clearLogs();
        txValid = 1'b1;
        enB = 1'b0;
        qA = '{8'h77};
        lqA = '{1'b1};
        enA = 1'b1;
        for (int i = 0; i < 10 && !gntA; i++) @(negedge clk);
        @(negedge clk);
        enA = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!gntA) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || ackACnt != 0 || errCyc.size() != 0 || txLog.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_drop got=released%0d ack%0d err%0d txen%0d busy%0d want=1 0 0 0 0",
                     ok, ackACnt, errCyc.size(), txLog.size(), busy);
        end
        qA.delete();
        lqA.delete();
        txValid = 1'b0;
        enA = 1'b1;
        enB = 1'b1;
        expLastB = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clearLogs();
        hangCount = 1;
        lat = 2;
        enB = 1'b0;
        qA = '{8'h3C};
        lqA = '{1'b1};
        enA = 1'b1;
        waitTx(1, 20, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b1 || ackACnt != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_setup got=ok%0d busy%0d ack%0d want=1 1 0", ok, busy, ackACnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gntA, gntB, ackA, ackB, txen, err, busy} !== 7'b0 || txData !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs got=%b/%h want=0000000/00", {gntA, gntB, ackA, ackB, txen, err, busy}, txData);
        end
        enA = 1'b0;
        enB = 1'b0;
        hangCount = 0;
        qA.delete();
        lqA.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
        qA = '{8'hC1};
        lqA = '{1'b1};
        qB = '{8'hC2};
        lqB = '{1'b1};
        @(negedge clk);
        enA = 1'b1;
        enB = 1'b1;
        waitDone(200, ok);
        checks++;
        if (!ok || txLog.size() != 2 || txOwn[0] !== 1'b0 || txOwn[1] !== 1'b1 || txLog[0] !== 8'hC1 || ackACnt != 1) begin
            errors++;
            $display("[TB] FAIL rstmid_restart got=n%0d ackA%0d want=n2 A-first ackA1", txLog.size(), ackACnt);
        end
        checks++;
        if (sawBoth !== 1'b0) begin
            errors++;
            $display("[TB] FAIL one_hot_grant got=both_high want=never");
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single();
        test_backpressure();
        test_watchdog();
        test_fairness_random();
        test_early_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout got=running want=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
